// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and memory hold.
// Optional load-use bubble counter on o_bubble_cnt when SOIN_HAZARD_PERF_EN is defined.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ID_valid,
  input  logic [4:0]      i_ID_rnum1,
  input  logic [4:0]      i_ID_rnum2,
  input  logic            i_ID_ren1,
  input  logic            i_ID_ren2,
  input  logic [4:0]      i_ID_wnum,
  input  logic            i_ID_wen,
  input  logic            i_ID_memRead,
  input  logic            i_ID_memWrite,
  input  logic [3:0]      i_ID_aluop,
  input  logic [XLEN-1:0] i_ID_rdata1,
  input  logic [XLEN-1:0] i_ID_rdata2,
  input  logic [XLEN-1:0] i_ID_imm,
  input  logic [XLEN-1:0] i_ID_pc,
  input  logic            i_flush,
  input  logic            i_hold,
  output logic            o_EX_valid,
  output logic            o_EX_wen,
  output logic            o_EX_memRead,
  output logic            o_EX_memWrite,
  output logic [4:0]      o_EX_rnum1,
  output logic [4:0]      o_EX_rnum2,
  output logic [4:0]      o_EX_wnum,
  output logic [3:0]      o_EX_aluop,
  output logic [XLEN-1:0] o_EX_rdata1,
  output logic [XLEN-1:0] o_EX_rdata2,
  output logic [XLEN-1:0] o_EX_imm,
  output logic [XLEN-1:0] o_EX_pc,
`ifdef SOIN_HAZARD_PERF_EN
  output logic [31:0]     o_bubble_cnt,
`endif
  output logic            o_ID_stall
);

  logic src1_hit;
  logic src2_hit;
  logic load_use;
  logic bubble;

  // A load targeting x0 never produces a value worth waiting for.
  assign src1_hit = i_ID_ren1 && (i_ID_rnum1 == o_EX_wnum);
  assign src2_hit = i_ID_ren2 && (i_ID_rnum2 == o_EX_wnum);
  assign load_use = o_EX_valid && o_EX_memRead && (o_EX_wnum != 5'd0) &&
                    i_ID_valid && (src1_hit || src2_hit);

  assign o_ID_stall = i_hold || (load_use && !i_flush);
  assign bubble     = i_flush || load_use;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_EX_valid    <= 1'b0;
      o_EX_wen      <= 1'b0;
      o_EX_memRead  <= 1'b0;
      o_EX_memWrite <= 1'b0;
      o_EX_rnum1    <= 5'd0;
      o_EX_rnum2    <= 5'd0;
      o_EX_wnum     <= 5'd0;
      o_EX_aluop    <= 4'd0;
      o_EX_rdata1   <= '0;
      o_EX_rdata2   <= '0;
      o_EX_imm      <= '0;
      o_EX_pc       <= '0;
    end else if (!i_hold) begin
      if (bubble) begin
        o_EX_valid    <= 1'b0;
        o_EX_wen      <= 1'b0;
        o_EX_memRead  <= 1'b0;
        o_EX_memWrite <= 1'b0;
        o_EX_rnum1    <= 5'd0;
        o_EX_rnum2    <= 5'd0;
        o_EX_wnum     <= 5'd0;
        o_EX_aluop    <= 4'd0;
        o_EX_rdata1   <= '0;
        o_EX_rdata2   <= '0;
        o_EX_imm      <= '0;
        o_EX_pc       <= '0;
      end else begin
        // Side-effecting controls are squashed for an invalid slot; the rest passes through.
        o_EX_valid    <= i_ID_valid;
        o_EX_wen      <= i_ID_wen && i_ID_valid;
        o_EX_memRead  <= i_ID_memRead && i_ID_valid;
        o_EX_memWrite <= i_ID_memWrite && i_ID_valid;
        o_EX_rnum1    <= i_ID_rnum1;
        o_EX_rnum2    <= i_ID_rnum2;
        o_EX_wnum     <= i_ID_wnum;
        o_EX_aluop    <= i_ID_aluop;
        o_EX_rdata1   <= i_ID_rdata1;
        o_EX_rdata2   <= i_ID_rdata2;
        o_EX_imm      <= i_ID_imm;
        o_EX_pc       <= i_ID_pc;
      end
    end
  end

`ifdef SOIN_HAZARD_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bubble_cnt <= 32'd0;
    end else if (!i_hold && !i_flush && load_use) begin
      o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vector table, hold/reset sequences and random traffic
// checked against a transaction-level pipeline model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rnum1;
    logic [4:0]  rnum2;
    logic        ren1;
    logic        ren2;
    logic [4:0]  wnum;
    logic        wen;
    logic        mr;
    logic        mw;
    logic [3:0]  aluop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        mr;
    logic        mw;
    logic [4:0]  rnum1;
    logic [4:0]  rnum2;
    logic [4:0]  wnum;
    logic [3:0]  aluop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  typedef struct {
    id_t         id;
    logic        hold;
    logic        flush;
    logic        exp_stall;
    logic        exp_valid;
    logic [4:0]  exp_wnum;
    logic        exp_mr;
    logic        exp_wen;
    logic [31:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  id_t  id;
  logic flush, hold;
  logic ex_valid, ex_wen, ex_mr, ex_mw, stall;
  logic [4:0] ex_rnum1, ex_rnum2, ex_wnum;
  logic [3:0] ex_aluop;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
`ifdef SOIN_HAZARD_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  ex_t         m_ex;
  int unsigned m_bubbles;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ID_valid(id.valid), .i_ID_rnum1(id.rnum1), .i_ID_rnum2(id.rnum2),
    .i_ID_ren1(id.ren1), .i_ID_ren2(id.ren2), .i_ID_wnum(id.wnum), .i_ID_wen(id.wen),
    .i_ID_memRead(id.mr), .i_ID_memWrite(id.mw), .i_ID_aluop(id.aluop),
    .i_ID_rdata1(id.rd1), .i_ID_rdata2(id.rd2), .i_ID_imm(id.imm), .i_ID_pc(id.pc),
    .i_flush(flush), .i_hold(hold),
    .o_EX_valid(ex_valid), .o_EX_wen(ex_wen), .o_EX_memRead(ex_mr), .o_EX_memWrite(ex_mw),
    .o_EX_rnum1(ex_rnum1), .o_EX_rnum2(ex_rnum2), .o_EX_wnum(ex_wnum), .o_EX_aluop(ex_aluop),
    .o_EX_rdata1(ex_rd1), .o_EX_rdata2(ex_rd2), .o_EX_imm(ex_imm), .o_EX_pc(ex_pc),
`ifdef SOIN_HAZARD_PERF_EN
    .o_bubble_cnt(bubble_cnt),
`endif
    .o_ID_stall(stall)
  );

  function automatic ex_t dut_ex();
    ex_t e;
    e = '{ex_valid, ex_wen, ex_mr, ex_mw, ex_rnum1, ex_rnum2, ex_wnum, ex_aluop,
          ex_rd1, ex_rd2, ex_imm, ex_pc};
    return e;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Does the instruction in ID need the result of the load sitting in EX?
  function automatic logic m_hazard(input ex_t e, input id_t d);
    logic needs;
    needs = (d.ren1 && d.rnum1 == e.wnum) || (d.ren2 && d.rnum2 == e.wnum);
    return e.valid && e.mr && e.wnum != 0 && d.valid && needs;
  endfunction

  function automatic ex_t m_capture(input id_t d);
    ex_t e;
    e = '{d.valid, d.wen & d.valid, d.mr & d.valid, d.mw & d.valid, d.rnum1, d.rnum2,
          d.wnum, d.aluop, d.rd1, d.rd2, d.imm, d.pc};
    return e;
  endfunction

  // One pipeline cycle: drive, check stall mid-cycle, clock, check EX and counter.
  task automatic cycle(input id_t d, input logic h, input logic f, input string tag);
    logic lu;
    ex_t  nxt;
    id = d; hold = h; flush = f;
    @(negedge clk);
    lu = m_hazard(m_ex, d);
    chk({tag, "_stall"}, 192'(stall), 192'(h || (lu && !f)));
    if (h) nxt = m_ex;
    else if (f || lu) nxt = '0;
    else nxt = m_capture(d);
    if (!h && !f && lu) m_bubbles++;
    @(posedge clk); #1;
    m_ex = nxt;
    chk({tag, "_ex"}, 192'(dut_ex()), 192'(m_ex));
`ifdef SOIN_HAZARD_PERF_EN
    chk({tag, "_bubble_cnt"}, 192'(bubble_cnt), 192'(m_bubbles));
`endif
  endtask

  function automatic id_t mk(input logic v, input logic [4:0] r1, input logic r1e,
                             input logic [4:0] r2, input logic r2e, input logic [4:0] w,
                             input logic we, input logic ld, input logic [31:0] pc);
    id_t d;
    d = '{v, r1, r2, r1e, r2e, w, we, ld, 1'b0, 4'(pc[5:2]), pc ^ 32'hA5A5_0000,
          pc ^ 32'h0000_5A5A, pc + 32'd16, pc};
    return d;
  endfunction

  vec_t vecs[$];
  id_t  ld5, dep5, r;

  initial begin
    rst = 1'b1; id = '0; hold = 1'b0; flush = 1'b0;
    m_ex = '0; m_bubbles = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex", 192'(dut_ex()), 192'(0));
    chk("reset_stall", 192'(stall), 192'(0));
    rst = 1'b0;

    //             valid r1 e  r2 e  w  we ld  pc
    vecs.push_back('{mk(1, 3, 1, 0, 0, 5, 1, 0, 32'h100), 0, 0, 0, 1, 5, 0, 1, 32'h100});
    vecs.push_back('{mk(1, 1, 1, 0, 0, 5, 1, 1, 32'h104), 0, 0, 0, 1, 5, 1, 1, 32'h104});
    vecs.push_back('{mk(1, 5, 1, 0, 0, 6, 1, 0, 32'h108), 0, 0, 1, 0, 0, 0, 0, 32'h0});
    vecs.push_back('{mk(1, 5, 1, 0, 0, 6, 1, 0, 32'h108), 0, 0, 0, 1, 6, 0, 1, 32'h108});
    vecs.push_back('{mk(1, 1, 1, 0, 0, 0, 1, 1, 32'h10c), 0, 0, 0, 1, 0, 1, 1, 32'h10c});
    vecs.push_back('{mk(1, 0, 1, 0, 0, 7, 1, 0, 32'h110), 0, 0, 0, 1, 7, 0, 1, 32'h110});
    vecs.push_back('{mk(1, 1, 1, 0, 0, 5, 1, 1, 32'h114), 0, 0, 0, 1, 5, 1, 1, 32'h114});
    vecs.push_back('{mk(1, 2, 1, 5, 0, 8, 1, 0, 32'h118), 0, 0, 0, 1, 8, 0, 1, 32'h118});
    vecs.push_back('{mk(1, 1, 1, 0, 0, 5, 1, 1, 32'h11c), 0, 0, 0, 1, 5, 1, 1, 32'h11c});
    vecs.push_back('{mk(1, 5, 1, 0, 0, 6, 1, 0, 32'h120), 0, 1, 0, 0, 0, 0, 0, 32'h0});
    vecs.push_back('{mk(0, 1, 1, 0, 0, 9, 1, 1, 32'h124), 0, 0, 0, 0, 9, 0, 0, 32'h124});
    vecs.push_back('{mk(1, 1, 1, 0, 0, 4, 1, 1, 32'h128), 0, 0, 0, 1, 4, 1, 1, 32'h128});
    vecs.push_back('{mk(1, 4, 0, 4, 1, 4, 1, 1, 32'h12c), 0, 0, 1, 0, 0, 0, 0, 32'h0});
    vecs.push_back('{mk(1, 4, 0, 4, 1, 4, 1, 1, 32'h12c), 0, 0, 0, 1, 4, 1, 1, 32'h12c});
    vecs.push_back('{mk(1, 4, 1, 0, 0, 2, 1, 0, 32'h130), 0, 0, 1, 0, 0, 0, 0, 32'h0});

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      id = vecs[i].id; hold = vecs[i].hold; flush = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 192'(stall), 192'(vecs[i].exp_stall));
      if (!vecs[i].hold && !vecs[i].flush && m_hazard(m_ex, vecs[i].id)) m_bubbles++;
      @(posedge clk); #1;
      m_ex = vecs[i].flush || vecs[i].exp_stall ? ex_t'(0) : m_capture(vecs[i].id);
      chk($sformatf("vec%0d_valid", i), 192'(ex_valid), 192'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_wnum", i), 192'(ex_wnum), 192'(vecs[i].exp_wnum));
      chk($sformatf("vec%0d_memread", i), 192'(ex_mr), 192'(vecs[i].exp_mr));
      chk($sformatf("vec%0d_wen", i), 192'(ex_wen), 192'(vecs[i].exp_wen));
      chk($sformatf("vec%0d_pc", i), 192'(ex_pc), 192'(vecs[i].exp_pc));
    end
`ifdef SOIN_HAZARD_PERF_EN
    chk("vec_bubble_cnt", 192'(bubble_cnt), 192'(3));
`endif

    // Hold for three cycles with a load-use pending, then one bubble, then the consumer.
    ld5  = mk(1, 1, 1, 0, 0, 5, 1, 1, 32'h200);
    dep5 = mk(1, 5, 1, 0, 0, 6, 1, 0, 32'h204);
    cycle(ld5, 0, 0, "hold_ld");
    for (int k = 0; k < 3; k++) begin
      cycle(dep5, 1, 0, $sformatf("hold%0d", k));
      chk($sformatf("hold%0d_pc", k), 192'(ex_pc), 192'(32'h200));
      chk($sformatf("hold%0d_memread", k), 192'(ex_mr), 192'(1));
    end
    cycle(dep5, 0, 0, "hold_bubble");
    chk("hold_bubble_valid", 192'(ex_valid), 192'(0));
    cycle(dep5, 0, 0, "hold_dep");
    chk("hold_dep_pc", 192'(ex_pc), 192'(32'h204));

    for (int n = 0; n < 400; n++) begin
      r = '{($urandom % 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom % 3) == 0, 1'($urandom), 4'($urandom), $urandom, $urandom,
            $urandom, $urandom};
      cycle(r, ($urandom % 6) == 0, ($urandom % 8) == 0, "rand");
    end

    // Asynchronous reset in the middle of a cycle with a valid instruction in EX.
    cycle(mk(1, 1, 1, 2, 1, 3, 1, 1, 32'h300), 0, 0, "arst_pre");
    chk("arst_pre_valid", 192'(ex_valid), 192'(1));
    #2 rst = 1'b1;
    #1;
    m_ex = '0; m_bubbles = 0;
    chk("arst_ex", 192'(dut_ex()), 192'(0));
    chk("arst_stall", 192'(stall), 192'(0));
`ifdef SOIN_HAZARD_PERF_EN
    chk("arst_bubble_cnt", 192'(bubble_cnt), 192'(0));
`endif
    hold = 1'b1;
    #1;
    chk("arst_stall_hold", 192'(stall), 192'(1));
    rst = 1'b0; hold = 1'b0;
    cycle(mk(1, 2, 1, 0, 0, 4, 1, 0, 32'h304), 0, 0, "arst_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
